// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD conversion scheduler
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BIN_W   = 7;
    localparam int BCD_W   = 8;
    localparam int STEPS   = 7;
    localparam int SAT_MAX = 99;

endpackage

// File: rtl/bcd_dabble_step.sv
// rtl/bcd_dabble_step.sv - one combinational shift-add-3 step of the binary to BCD conversion
module bcd_dabble_step
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] acc,
    input  logic             msb,
    output logic [BCD_W-1:0] acc_nxt
);

    logic [3:0]       tens_adj;
    logic [3:0]       units_adj;
    logic [BCD_W-1:0] adj;

    // Correct each digit before the shift so it cannot leave the 0..9 range afterwards.
    always_comb begin
        tens_adj  = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
        units_adj = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
        adj       = {tens_adj, units_adj};
        acc_nxt   = (adj << 1) | {{(BCD_W-1){1'b0}}, msb};
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin shared 7-bit binary to 2-digit BCD converter with per-channel result registers
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         req,
    input  logic [N*BIN_W-1:0]   bin,
    input  logic                 flush,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [BCD_W-1:0]     bcd,
    output logic                 ovf,
    output logic [N*BCD_W-1:0]   bcd_all
);

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   winner;
    logic             found;
    logic             grant_en;
    logic             finish;
    logic [BIN_W-1:0] opnd;
    logic [BIN_W-1:0] win_opnd;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_nxt;
    logic [2:0]       cnt;
    logic             sat_flag;

    bcd_dabble_step u_step (
        .acc     (acc),
        .msb     (opnd[BIN_W-1]),
        .acc_nxt (acc_nxt)
    );

    // Scan starts one past the last winner, so the last winner has lowest priority.
    always_comb begin : arbiter
        int k;
        found    = 1'b0;
        winner   = '0;
        win_opnd = '0;
        k        = 0;
        for (int i = 1; i <= N; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k]) begin
                found    = 1'b1;
                winner   = IDW'(k);
                win_opnd = bin[k*BIN_W +: BIN_W];
            end
        end
    end

    always_comb begin : fsm
        state_nxt = state;
        grant_en  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (found && !flush) begin
                    grant_en  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST_STEP) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            rr_ptr   <= IDW'(N - 1);
            id       <= '0;
            opnd     <= '0;
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            gnt      <= '0;
            done     <= 1'b0;
            done_id  <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
            bcd_all  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= '0;
            done  <= 1'b0;

            if (grant_en) begin
                gnt    <= {{(N-1){1'b0}}, 1'b1} << winner;
                id     <= winner;
                rr_ptr <= winner;
                acc    <= '0;
                cnt    <= '0;
                // Out-of-range operands saturate so the result always fits two digits.
                if (win_opnd > BIN_W'(SAT_MAX)) begin
                    opnd     <= BIN_W'(SAT_MAX);
                    sat_flag <= 1'b1;
                end else begin
                    opnd     <= win_opnd;
                    sat_flag <= 1'b0;
                end
            end

            if (state == SHIFT && !flush) begin
                acc  <= acc_nxt;
                opnd <= {opnd[BIN_W-2:0], 1'b0};
                cnt  <= cnt + 3'd1;
            end

            if (finish) begin
                done                             <= 1'b1;
                bcd                              <= acc_nxt;
                done_id                          <= id;
                ovf                              <= sat_flag;
                bcd_all[int'(id)*BCD_W +: BCD_W] <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - randomized self-checking bench for bcd_conv_sched against an arithmetic reference model
module tb_bcd_conv_sched;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic [N-1:0]     req;
    logic [N*7-1:0]   bin;
    logic             flush;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             done;
    logic [IDW-1:0]   done_id;
    logic [7:0]       bcd;
    logic             ovf;
    logic [N*8-1:0]   bcd_all;

    int               checks = 0;
    int               errors = 0;
    int               model_rr;
    logic [7:0]       exp_all [N];

    bcd_conv_sched #(.N(N), .IDW(IDW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .bin     (bin),
        .flush   (flush),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .bcd     (bcd),
        .ovf     (ovf),
        .bcd_all (bcd_all)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_bcd(input int v);
        int s;
        s = (v > 99) ? 99 : v;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int onehot_id(input logic [N-1:0] g);
        int r;
        r = -1;
        if ($onehot(g)) begin
            for (int i = 0; i < N; i++) if (g[i]) r = i;
        end
        return r;
    endfunction

    function automatic int model_pick(input int rr, input logic [N-1:0] r);
        int k;
        for (int i = 1; i <= N; i++) begin
            k = (rr + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N*8-1:0] pack_all();
        logic [N*8-1:0] p;
        for (int i = 0; i < N; i++) p[i*8 +: 8] = exp_all[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        model_rr = N - 1;
        for (int i = 0; i < N; i++) exp_all[i] = 8'h00;
    endtask

    // Drives one single-channel request and reports what the DUT did; comparisons live in the tests.
    task automatic run_conv(input int ch, input int val, output logic [N-1:0] g, output int lat,
                            output int bn, output logic [7:0] b, output logic [IDW-1:0] id, output logic o);
        int t;
        g = '0; lat = -1; bn = 0; b = '0; id = '0; o = 1'b0;
        bin[ch*7 +: 7] = 7'(val);
        req = '0;
        req[ch] = 1'b1;
        t = 0;
        while (gnt == '0 && t < 20) begin
            tick();
            t++;
        end
        g = gnt;
        req = '0;
        if (g != '0) begin
            t = 0;
            while (t < 20) begin
                if (busy) bn++;
                tick();
                t++;
                if (done) begin
                    lat = t; b = bcd; id = done_id; o = ovf;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        req = '0; flush = 1'b0; bin = '0; resetn = 1'b0;
        tick();
        checks++; if (gnt !== '0)     begin errors++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bcd !== 8'h00)  begin errors++; $display("FAIL reset_bcd got=%h exp=00", bcd); end
        checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (done_id !== '0) begin errors++; $display("FAIL reset_done_id got=%0d exp=0", done_id); end
        checks++; if (bcd_all !== '0) begin errors++; $display("FAIL reset_bcd_all got=%h exp=0", bcd_all); end
        tick();
        resetn = 1'b1;
        clear_model();
    endtask

    task automatic test_single();
        logic [N-1:0] g; int lat, bn; logic [7:0] b; logic [IDW-1:0] id; logic o;
        run_conv(0, 42, g, lat, bn, b, id, o);
        checks++; if (g !== 4'b0001)          begin errors++; $display("FAIL single_gnt got=%b exp=0001", g); end
        checks++; if (lat != 7)               begin errors++; $display("FAIL single_latency got=%0d exp=7", lat); end
        checks++; if (bn != 7)                begin errors++; $display("FAIL single_busy_cycles got=%0d exp=7", bn); end
        checks++; if (b !== 8'h42)            begin errors++; $display("FAIL single_bcd got=%h exp=42", b); end
        checks++; if (id !== 2'd0)            begin errors++; $display("FAIL single_done_id got=%0d exp=0", id); end
        checks++; if (o !== 1'b0)             begin errors++; $display("FAIL single_ovf got=%b exp=0", o); end
        checks++; if (bcd_all[7:0] !== 8'h42) begin errors++; $display("FAIL single_bcd_all got=%h exp=42", bcd_all[7:0]); end
        exp_all[0] = 8'h42;
        model_rr = 0;
    endtask

    task automatic test_values();
        int vals [5] = '{0, 9, 10, 99, 127};
        for (int n = 0; n < 13; n++) begin
            int ch, v, lat, bn;
            logic [N-1:0] g, eg; logic [7:0] b; logic [IDW-1:0] id; logic o;
            ch = (n < 5) ? 1 : int'($urandom_range(0, N - 1));
            v  = (n < 5) ? vals[n] : int'($urandom_range(0, 127));
            run_conv(ch, v, g, lat, bn, b, id, o);
            eg = '0; eg[ch] = 1'b1;
            checks++; if (g !== eg)             begin errors++; $display("FAIL values_gnt ch=%0d got=%b exp=%b", ch, g, eg); end
            checks++; if (lat != 7)             begin errors++; $display("FAIL values_latency v=%0d got=%0d exp=7", v, lat); end
            checks++; if (bn != 7)              begin errors++; $display("FAIL values_busy_cycles got=%0d exp=7", bn); end
            checks++; if (b !== ref_bcd(v))     begin errors++; $display("FAIL values_bcd v=%0d got=%h exp=%h", v, b, ref_bcd(v)); end
            checks++; if (o !== (v > 99))       begin errors++; $display("FAIL values_ovf v=%0d got=%b exp=%b", v, o, (v > 99)); end
            checks++; if (id !== IDW'(ch))      begin errors++; $display("FAIL values_done_id got=%0d exp=%0d", id, ch); end
            checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL values_busy_at_done got=%b exp=0", busy); end
            exp_all[ch] = ref_bcd(v);
            checks++; if (bcd_all !== pack_all()) begin errors++; $display("FAIL values_bcd_all got=%h exp=%h", bcd_all, pack_all()); end
            model_rr = ch;
        end
    endtask

    task automatic test_round_robin();
        int ng, nd, cyc, lastg, last, ex;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        clear_model();
        bin = {7'd44, 7'd33, 7'd22, 7'd11};
        req = '1;
        ng = 0; nd = 0; cyc = 0; lastg = 0; last = -1;
        while (nd < 5 && cyc < 80) begin
            tick();
            cyc++;
            if (done) begin
                nd++;
                checks++; if (int'(done_id) != last) begin errors++; $display("FAIL rr_done_id got=%0d exp=%0d", done_id, last); end
                checks++; if (bcd !== ref_bcd(11 * (last + 1))) begin errors++; $display("FAIL rr_bcd got=%h exp=%h", bcd, ref_bcd(11 * (last + 1))); end
                exp_all[last] = ref_bcd(11 * (last + 1));
            end
            if (gnt != '0) begin
                ex = model_pick(model_rr, req);
                checks++; if (onehot_id(gnt) != ex) begin errors++; $display("FAIL rr_order got=%b exp_ch=%0d", gnt, ex); end
                if (ng > 0) begin
                    checks++; if (cyc - lastg != 8) begin errors++; $display("FAIL rr_spacing got=%0d exp=8", cyc - lastg); end
                end
                model_rr = ex; last = ex; lastg = cyc; ng++;
                if (ng == 5) req = '0;
            end
        end
        checks++; if (ng != 5) begin errors++; $display("FAIL rr_grant_count got=%0d exp=5", ng); end
        checks++; if (nd != 5) begin errors++; $display("FAIL rr_done_count got=%0d exp=5", nd); end
        checks++; if (bcd_all !== 32'h44332211) begin errors++; $display("FAIL rr_bcd_all got=%h exp=44332211", bcd_all); end
    endtask

    task automatic test_random_arb();
        int ng, nd, cyc, lastg, last, ex, opv;
        ng = 0; nd = 0; cyc = 0; lastg = 0; last = -1; opv = 0;
        req = N'($urandom_range(1, (1 << N) - 1));
        bin = (N*7)'($urandom);
        while (nd < 12 && cyc < 250) begin
            tick();
            cyc++;
            if (done) begin
                nd++;
                checks++; if (int'(done_id) != last) begin errors++; $display("FAIL rand_done_id got=%0d exp=%0d", done_id, last); end
                checks++; if (bcd !== ref_bcd(opv))  begin errors++; $display("FAIL rand_bcd op=%0d got=%h exp=%h", opv, bcd, ref_bcd(opv)); end
                checks++; if (ovf !== (opv > 99))    begin errors++; $display("FAIL rand_ovf op=%0d got=%b exp=%b", opv, ovf, (opv > 99)); end
                if (last >= 0) exp_all[last] = ref_bcd(opv);
            end
            if (gnt != '0) begin
                ex = model_pick(model_rr, req);
                checks++; if (onehot_id(gnt) != ex) begin errors++; $display("FAIL rand_winner req=%b got=%b exp_ch=%0d", req, gnt, ex); end
                if (ng > 0) begin
                    checks++; if (cyc - lastg != 8) begin errors++; $display("FAIL rand_spacing got=%0d exp=8", cyc - lastg); end
                end
                if (ex >= 0) opv = int'(bin[ex*7 +: 7]);
                model_rr = ex; last = ex; lastg = cyc; ng++;
                if (ng == 12) begin
                    req = '0;
                end else if (ng % 3 == 0) begin
                    req = N'($urandom_range(1, (1 << N) - 1));
                    bin = (N*7)'($urandom);
                end
            end
        end
        checks++; if (nd != 12) begin errors++; $display("FAIL rand_done_count got=%0d exp=12", nd); end
        checks++; if (bcd_all !== pack_all()) begin errors++; $display("FAIL rand_bcd_all got=%h exp=%h", bcd_all, pack_all()); end
    endtask

    task automatic test_flush();
        logic [N-1:0] g; int lat, bn, t, v3; logic [7:0] b; logic [IDW-1:0] id; logic o;
        run_conv(2, 35, g, lat, bn, b, id, o);
        checks++; if (b !== 8'h35) begin errors++; $display("FAIL flush_pre_bcd got=%h exp=35", b); end
        exp_all[2] = 8'h35;
        model_rr = 2;
        bin[14 +: 7] = 7'd57;
        req = 4'b0100;
        t = 0;
        while (gnt == '0 && t < 20) begin tick(); t++; end
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL flush_gnt2 got=%b exp=0100", gnt); end
        req = '0;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got=%b exp=1", busy); end
        v3 = int'($urandom_range(1, 127));
        bin[21 +: 7] = 7'(v3);
        bin[0 +: 7] = 7'($urandom_range(0, 127));
        flush = 1'b1;
        req = 4'b1001;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL flush_busy_after got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)           begin errors++; $display("FAIL flush_done got=%b exp=0", done); end
        checks++; if (bcd !== 8'h35)           begin errors++; $display("FAIL flush_bcd_held got=%h exp=35", bcd); end
        checks++; if (bcd_all[23:16] !== 8'h35) begin errors++; $display("FAIL flush_slot2 got=%h exp=35", bcd_all[23:16]); end
        tick();
        checks++; if (onehot_id(gnt) != model_pick(model_rr, 4'b1001)) begin errors++; $display("FAIL flush_next_gnt got=%b exp_ch=%0d", gnt, model_pick(model_rr, 4'b1001)); end
        model_rr = 3;
        req = '0;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (done) begin lat = c; break; end
        end
        checks++; if (lat != 7)             begin errors++; $display("FAIL flush_ch3_latency got=%0d exp=7", lat); end
        checks++; if (done_id !== 2'd3)     begin errors++; $display("FAIL flush_ch3_id got=%0d exp=3", done_id); end
        checks++; if (bcd !== ref_bcd(v3))  begin errors++; $display("FAIL flush_ch3_bcd got=%h exp=%h", bcd, ref_bcd(v3)); end
        exp_all[3] = ref_bcd(v3);
        checks++; if (bcd_all !== pack_all()) begin errors++; $display("FAIL flush_bcd_all got=%h exp=%h", bcd_all, pack_all()); end
    endtask

    task automatic test_reset_mid();
        int t, v2, lat;
        bin[7 +: 7] = 7'd77;
        req = 4'b0010;
        t = 0;
        while (gnt == '0 && t < 20) begin tick(); t++; end
        req = '0;
        tick();
        tick();
        #2 resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (bcd !== 8'h00)  begin errors++; $display("FAIL rstmid_bcd got=%h exp=00", bcd); end
        checks++; if (done_id !== '0) begin errors++; $display("FAIL rstmid_done_id got=%0d exp=0", done_id); end
        checks++; if (bcd_all !== '0) begin errors++; $display("FAIL rstmid_bcd_all got=%h exp=0", bcd_all); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
        @(posedge clk);
        #1 resetn = 1'b1;
        clear_model();
        v2 = int'($urandom_range(0, 127));
        bin[14 +: 7] = 7'(v2);
        bin[21 +: 7] = 7'($urandom_range(0, 127));
        req = 4'b1100;
        t = 0;
        while (gnt == '0 && t < 20) begin tick(); t++; end
        checks++; if (onehot_id(gnt) != model_pick(model_rr, 4'b1100)) begin errors++; $display("FAIL rstmid_first_gnt got=%b exp_ch=%0d", gnt, model_pick(model_rr, 4'b1100)); end
        model_rr = 2;
        req = '0;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (done) begin lat = c; break; end
        end
        checks++; if (lat != 7 || done_id !== 2'd2) begin errors++; $display("FAIL rstmid_done lat=%0d id=%0d exp lat=7 id=2", lat, done_id); end
        checks++; if (bcd !== ref_bcd(v2) || ovf !== (v2 > 99)) begin errors++; $display("FAIL rstmid_bcd got=%h/%b exp=%h/%b", bcd, ovf, ref_bcd(v2), (v2 > 99)); end
        exp_all[2] = ref_bcd(v2);
    endtask

    task automatic test_withdraw();
        int t, v0, ng, nd;
        v0 = int'($urandom_range(0, 127));
        bin[0 +: 7] = 7'(v0);
        bin[7 +: 7] = 7'($urandom_range(0, 127));
        req = 4'b0001;
        t = 0;
        while (gnt == '0 && t < 20) begin tick(); t++; end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wd_first_gnt got=%b exp=0001", gnt); end
        model_rr = 0;
        ng = 0; nd = 0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 1) req = 4'b0011;
            if (c == 4) req = 4'b0001;
            tick();
            if (done) begin
                nd++;
                checks++; if (done_id !== 2'd0 || bcd !== ref_bcd(v0)) begin errors++; $display("FAIL wd_done id=%0d bcd=%h exp id=0 bcd=%h", done_id, bcd, ref_bcd(v0)); end
            end
            if (gnt != '0) begin
                ng++;
                checks++; if (gnt !== 4'b0001 || c != 8) begin errors++; $display("FAIL wd_regrant got=%b at=%0d exp=0001 at=8", gnt, c); end
                req = '0;
            end
        end
        checks++; if (ng != 1) begin errors++; $display("FAIL wd_grant_count got=%0d exp=1", ng); end
        checks++; if (nd != 2) begin errors++; $display("FAIL wd_done_count got=%0d exp=2", nd); end
        exp_all[0] = ref_bcd(v0);
        checks++; if (bcd_all !== pack_all()) begin errors++; $display("FAIL wd_bcd_all got=%h exp=%h", bcd_all, pack_all()); end
    endtask

    initial begin
        resetn = 1'b0;
        req    = '0;
        bin    = '0;
        flush  = 1'b0;
        clear_model();
        test_reset();
        test_single();
        test_values();
        test_round_robin();
        test_random_arb();
        test_flush();
        test_reset_mid();
        test_withdraw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
